frag_agg_sched: RTL and testbench

- Scheduler and controller for the byte-granular fragment FIFO (changeFIFO) in the fragmentation/aggregation datapath.
- Arbitrates between two fragment sources with round-robin and packet lock, then steers each accepted fragment (1-4 bytes) into the FIFO.
- Tracks FIFO byte occupancy and issues reads that repack the bytes into 32-bit output words, ending each packet with a flagged partial word.

---
 rtl/frag_agg_sched.sv | 199 +++++++++++++++++++
 tb/tb_frag_agg_sched.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frag_agg_sched.sv
// Fragment scheduler: arbitrates two byte-fragment sources into a byte FIFO and
// repacks the FIFO contents into 32-bit output words, ending each packet with a last word.
module frag_agg_sched #(
    parameter int unsigned DEPTH_BYTES = 16,
    parameter int unsigned OCC_W       = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      s0_data,
    input  logic [2:0]       s0_bytes,
    input  logic             s0_last,
    input  logic             s0_valid,
    output logic             s0_ready,
    input  logic [31:0]      s1_data,
    input  logic [2:0]       s1_bytes,
    input  logic             s1_last,
    input  logic             s1_valid,
    output logic             s1_ready,
    output logic [31:0]      fifo_din,
    output logic [3:0]       fifo_din_index,
    output logic             fifo_wr_en,
    output logic [3:0]       fifo_dout_index,
    output logic             fifo_rd_en,
    input  logic [31:0]      fifo_dout,
    output logic [31:0]      m_data,
    output logic [2:0]       m_bytes,
    output logic             m_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [1:0]       grant,
    output logic [OCC_W-1:0] occ
);

    typedef enum logic [1:0] {IDLE, PACK, DRAIN} state_e;

    localparam logic [OCC_W-1:0] PACK_RD_MIN = OCC_W'(5);
    localparam logic [OCC_W-1:0] WORD_BYTES  = OCC_W'(4);
    localparam logic [OCC_W:0]   DEPTH       = (OCC_W+1)'(DEPTH_BYTES);

    state_e           state_q, state_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic [1:0]       grant_q, grant_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             m_valid_q, m_valid_d;
    logic [31:0]      m_data_q, m_data_d;
    logic [2:0]       m_bytes_q, m_bytes_d;
    logic             m_last_q, m_last_d;
    logic             rd_pending_q, rd_pending_d;
    logic [2:0]       rd_bytes_q, rd_bytes_d;
    logic             rd_last_q, rd_last_d;
    logic             last_issued_q, last_issued_d;

    logic             own_sel, own_valid, own_last, own_ready;
    logic [31:0]      own_data;
    logic [2:0]       own_raw, own_bytes, rd_cnt;
    logic [OCC_W:0]   occ_sum;
    logic             accept, wr, rd, rd_tag_last, zero_load, can_issue, m_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= 1'b0;
            grant_q       <= '0;
            occ_q         <= '0;
            m_valid_q     <= 1'b0;
            m_data_q      <= '0;
            m_bytes_q     <= '0;
            m_last_q      <= 1'b0;
            rd_pending_q  <= 1'b0;
            rd_bytes_q    <= '0;
            rd_last_q     <= 1'b0;
            last_issued_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_q       <= grant_d;
            occ_q         <= occ_d;
            m_valid_q     <= m_valid_d;
            m_data_q      <= m_data_d;
            m_bytes_q     <= m_bytes_d;
            m_last_q      <= m_last_d;
            rd_pending_q  <= rd_pending_d;
            rd_bytes_q    <= rd_bytes_d;
            rd_last_q     <= rd_last_d;
            last_issued_q <= last_issued_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (s0_valid || s1_valid) begin
                    state_d = PACK;
                    grant_d = (s0_valid && (!rr_ptr_q || !s1_valid)) ? 2'b01 : 2'b10;
                end
            end
            PACK: begin
                if (accept && own_last) state_d = DRAIN;
            end
            DRAIN: begin
                if (m_done) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    rr_ptr_d = ~own_sel;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        own_sel   = grant_q[1];
        own_valid = own_sel ? s1_valid : s0_valid;
        own_last  = own_sel ? s1_last  : s0_last;
        own_data  = own_sel ? s1_data  : s0_data;
        own_raw   = own_sel ? s1_bytes : s0_bytes;
        own_bytes = (own_raw > 3'd4) ? 3'd4 : own_raw;
        occ_sum   = {1'b0, occ_q} + (OCC_W+1)'(own_bytes);
        own_ready = !rst && (state_q == PACK) && (occ_sum <= DEPTH);
        accept    = own_ready && own_valid;
        wr        = accept && (own_bytes != 3'd0);
        m_done    = m_valid_q && m_ready && m_last_q;
        can_issue = !rst && !rd_pending_q && (!m_valid_q || m_ready);

        // PACK never drains below 1 byte, so DRAIN always has a tail (or a zero-byte packet) to tag last
        rd          = 1'b0;
        rd_cnt      = '0;
        rd_tag_last = 1'b0;
        zero_load   = 1'b0;
        if (can_issue) begin
            if (state_q == PACK && occ_q >= PACK_RD_MIN) begin
                rd     = 1'b1;
                rd_cnt = 3'd4;
            end else if (state_q == DRAIN && !last_issued_q) begin
                if (occ_q > WORD_BYTES) begin
                    rd     = 1'b1;
                    rd_cnt = 3'd4;
                end else if (occ_q != '0) begin
                    rd          = 1'b1;
                    rd_cnt      = occ_q[2:0];
                    rd_tag_last = 1'b1;
                end else begin
                    zero_load = 1'b1;
                end
            end
        end

        m_valid_d     = m_valid_q;
        m_data_d      = m_data_q;
        m_bytes_d     = m_bytes_q;
        m_last_d      = m_last_q;
        rd_pending_d  = rd_pending_q;
        rd_bytes_d    = rd_bytes_q;
        rd_last_d     = rd_last_q;
        last_issued_d = last_issued_q;
        if (m_valid_q && m_ready) m_valid_d = 1'b0;
        if (rd_pending_q) begin
            m_data_d     = fifo_dout;
            m_bytes_d    = rd_bytes_q;
            m_last_d     = rd_last_q;
            m_valid_d    = 1'b1;
            rd_pending_d = 1'b0;
        end
        if (rd) begin
            rd_pending_d = 1'b1;
            rd_bytes_d   = rd_cnt;
            rd_last_d    = rd_tag_last;
            if (rd_tag_last) last_issued_d = 1'b1;
        end
        if (zero_load) begin
            m_valid_d     = 1'b1;
            m_data_d      = '0;
            m_bytes_d     = '0;
            m_last_d      = 1'b1;
            last_issued_d = 1'b1;
        end
        if (state_q == DRAIN && m_done) last_issued_d = 1'b0;

        occ_d = occ_q + (wr ? OCC_W'(own_bytes) : '0) - (rd ? OCC_W'(rd_cnt) : '0);

        s0_ready        = own_ready && grant_q[0];
        s1_ready        = own_ready && grant_q[1];
        fifo_wr_en      = wr;
        fifo_din        = wr ? own_data : '0;
        fifo_din_index  = wr ? {1'b0, own_bytes} : '0;
        fifo_rd_en      = rd;
        fifo_dout_index = rd ? {1'b0, rd_cnt} : '0;
        m_valid         = m_valid_q;
        m_data          = m_data_q;
        m_bytes         = m_bytes_q;
        m_last          = m_last_q;
        grant           = grant_q;
        occ             = occ_q;
    end

endmodule

// File: tb/tb_frag_agg_sched.sv
// Bench for frag_agg_sched: byte-FIFO model on the FIFO ports, a per-cycle vector
// table for the single-packet case, and sequences for tails, contention, backpressure and reset.
module tb_frag_agg_sched;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned OW    = 5;

    logic          clk, rst;
    logic [31:0]   s0_data, s1_data, fifo_din, fifo_dout, m_data;
    logic [2:0]    s0_bytes, s1_bytes, m_bytes;
    logic          s0_last, s0_valid, s0_ready, s1_last, s1_valid, s1_ready;
    logic [3:0]    fifo_din_index, fifo_dout_index;
    logic          fifo_wr_en, fifo_rd_en, m_last, m_valid, m_ready;
    logic [1:0]    grant;
    logic [OW-1:0] occ;

    frag_agg_sched #(.DEPTH_BYTES(DEPTH), .OCC_W(OW)) dut (
        .clk(clk), .rst(rst),
        .s0_data(s0_data), .s0_bytes(s0_bytes), .s0_last(s0_last), .s0_valid(s0_valid), .s0_ready(s0_ready),
        .s1_data(s1_data), .s1_bytes(s1_bytes), .s1_last(s1_last), .s1_valid(s1_valid), .s1_ready(s1_ready),
        .fifo_din(fifo_din), .fifo_din_index(fifo_din_index), .fifo_wr_en(fifo_wr_en),
        .fifo_dout_index(fifo_dout_index), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
        .m_data(m_data), .m_bytes(m_bytes), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
        .grant(grant), .occ(occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte FIFO model: bytes are left-justified, first byte in [31:24]
    logic [7:0]  fq[$];
    logic        rd_due;
    logic [31:0] rd_word;
    int          fifo_errs = 0;
    int          wr_ops = 0;
    int          rd_ops = 0;

    always @(negedge clk) begin
        rd_due = 1'b0;
        if (rst) begin
            fq.delete();
        end else begin
            if (fifo_rd_en) begin
                rd_ops++;
                rd_word = '0;
                if (fifo_dout_index > 4'd4 || int'(fifo_dout_index) > fq.size()) fifo_errs++;
                else for (int i = 0; i < int'(fifo_dout_index); i++) rd_word[31-8*i -: 8] = fq.pop_front();
                rd_due = 1'b1;
            end
            if (fifo_wr_en) begin
                wr_ops++;
                if (fifo_din_index > 4'd4 || fq.size() + int'(fifo_din_index) > int'(DEPTH)) fifo_errs++;
                else for (int i = 0; i < int'(fifo_din_index); i++) fq.push_back(fifo_din[31-8*i -: 8]);
            end
        end
    end

    always @(posedge clk) if (rd_due) fifo_dout <= rd_word;

    typedef struct {
        logic s0v; logic [2:0] s0b; logic s0l; logic mr;
        logic e_s0r; logic e_wr; logic [3:0] e_dini; logic e_rd; logic [3:0] e_douti;
        logic [1:0] e_grant; logic [4:0] e_occ;
        logic e_mv; logic [2:0] e_mb; logic e_ml; logic [31:0] e_md;
    } vec_t;

    typedef struct { logic [31:0] d; logic [2:0] b; logic l; } word_t;

    int    n_chk = 0;
    int    n_fail = 0;
    word_t exp_q[$];
    bit    snap_s0, snap_s1, snap_s0r, snap_s1r;
    logic [1:0] snap_grant;
    vec_t  vt[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] bmask(input logic [2:0] b);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) if (i < int'(b)) m[31-8*i -: 8] = 8'hff;
        return m;
    endfunction

    // One clock: sample at negedge (handshakes + scoreboard), return 1 time unit after posedge
    task automatic step();
        word_t w;
        @(negedge clk);
        snap_s0    = s0_valid && s0_ready;
        snap_s1    = s1_valid && s1_ready;
        snap_s0r   = s0_ready;
        snap_s1r   = s1_ready;
        snap_grant = grant;
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL extra_word: got data 0x%0h bytes %0d last %0b, expected no word", m_data, m_bytes, m_last);
            end else begin
                w = exp_q.pop_front();
                chk("word_bytes", {29'd0, m_bytes}, {29'd0, w.b});
                chk("word_last", {31'd0, m_last}, {31'd0, w.l});
                chk("word_data", m_data & bmask(w.b), w.d);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit src, input logic [31:0] d, input logic [2:0] b, input logic l);
        bit done;
        done = 1'b0;
        if (src) begin s1_data = d; s1_bytes = b; s1_last = l; s1_valid = 1'b1; end
        else     begin s0_data = d; s0_bytes = b; s0_last = l; s0_valid = 1'b1; end
        for (int c = 0; c < 80 && !done; c++) begin
            step();
            done = src ? snap_s1 : snap_s0;
        end
        if (src) s1_valid = 1'b0; else s0_valid = 1'b0;
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: src %0d beat not accepted, required acceptance within 80 cycles", src);
        end else begin
            chk("other_ready_low", {31'd0, src ? snap_s0r : snap_s1r}, 32'd0);
            chk("grant_at_accept", {30'd0, snap_grant}, src ? 32'd2 : 32'd1);
        end
    endtask

    task automatic drain(input string nm);
        for (int c = 0; c < 120 && exp_q.size() != 0; c++) step();
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_drain_timeout: %0d words still outstanding, required 0", nm, exp_q.size());
            exp_q.delete();
        end
        chk({nm, "_grant_idle"}, {30'd0, grant}, 32'd0);
        chk({nm, "_occ_zero"}, {27'd0, occ}, 32'd0);
    endtask

    task automatic contend(input logic [31:0] d0, input logic [31:0] d1, output int first);
        bit acc0, acc1;
        acc0 = 1'b0; acc1 = 1'b0; first = -1;
        s0_data = d0; s0_bytes = 3'd4; s0_last = 1'b1; s0_valid = 1'b1;
        s1_data = d1; s1_bytes = 3'd4; s1_last = 1'b1; s1_valid = 1'b1;
        for (int c = 0; c < 120 && !(acc0 && acc1); c++) begin
            step();
            if (snap_s0) begin
                chk("cont_s0_grant", {30'd0, snap_grant}, 32'd1);
                chk("cont_s1_ready_low", {31'd0, snap_s1r}, 32'd0);
                acc0 = 1'b1; s0_valid = 1'b0;
                if (first < 0) first = 0;
            end
            if (snap_s1) begin
                chk("cont_s1_grant", {30'd0, snap_grant}, 32'd2);
                chk("cont_s0_ready_low", {31'd0, snap_s0r}, 32'd0);
                acc1 = 1'b1; s1_valid = 1'b0;
                if (first < 0) first = 1;
            end
        end
        s0_valid = 1'b0; s1_valid = 1'b0;
        if (!(acc0 && acc1)) begin
            n_chk++;
            n_fail++;
            $display("FAIL cont_timeout: accepted s0=%0b s1=%0b, required both", acc0, acc1);
        end
    endtask

    task automatic run_table(input string nm);
        for (int i = 0; i < 6; i++) begin
            s0_data = 32'h12345678; s0_valid = vt[i].s0v; s0_bytes = vt[i].s0b;
            s0_last = vt[i].s0l;    m_ready = vt[i].mr;
            @(negedge clk);
            chk($sformatf("%s_v%0d_s0_ready", nm, i), {31'd0, s0_ready}, {31'd0, vt[i].e_s0r});
            chk($sformatf("%s_v%0d_wr_en", nm, i), {31'd0, fifo_wr_en}, {31'd0, vt[i].e_wr});
            chk($sformatf("%s_v%0d_din_index", nm, i), {28'd0, fifo_din_index}, {28'd0, vt[i].e_dini});
            chk($sformatf("%s_v%0d_rd_en", nm, i), {31'd0, fifo_rd_en}, {31'd0, vt[i].e_rd});
            chk($sformatf("%s_v%0d_dout_index", nm, i), {28'd0, fifo_dout_index}, {28'd0, vt[i].e_douti});
            chk($sformatf("%s_v%0d_grant", nm, i), {30'd0, grant}, {30'd0, vt[i].e_grant});
            chk($sformatf("%s_v%0d_occ", nm, i), {27'd0, occ}, {27'd0, vt[i].e_occ});
            chk($sformatf("%s_v%0d_m_valid", nm, i), {31'd0, m_valid}, {31'd0, vt[i].e_mv});
            if (vt[i].e_wr) chk($sformatf("%s_v%0d_din", nm, i), fifo_din, 32'h12345678);
            if (vt[i].e_mv) begin
                chk($sformatf("%s_v%0d_m_bytes", nm, i), {29'd0, m_bytes}, {29'd0, vt[i].e_mb});
                chk($sformatf("%s_v%0d_m_last", nm, i), {31'd0, m_last}, {31'd0, vt[i].e_ml});
                chk($sformatf("%s_v%0d_m_data", nm, i), m_data, vt[i].e_md);
            end
            @(posedge clk);
            #1;
        end
        s0_valid = 1'b0;
        m_ready  = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        int first;
        int w0, r0;
        //          s0v   s0b   s0l   mr    s0r   wr    dini  rd    douti gnt    occ   mv    mb    ml    md
        vt[0] = '{1'b1, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 2'b00, 5'd0, 1'b0, 3'd0, 1'b0, 32'h0};
        vt[1] = '{1'b1, 3'd4, 1'b1, 1'b1, 1'b1, 1'b1, 4'd4, 1'b0, 4'd0, 2'b01, 5'd0, 1'b0, 3'd0, 1'b0, 32'h0};
        vt[2] = '{1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 4'd4, 2'b01, 5'd4, 1'b0, 3'd0, 1'b0, 32'h0};
        vt[3] = '{1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 2'b01, 5'd0, 1'b0, 3'd0, 1'b0, 32'h0};
        vt[4] = '{1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 2'b01, 5'd0, 1'b1, 3'd4, 1'b1, 32'h12345678};
        vt[5] = '{1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 2'b00, 5'd0, 1'b0, 3'd0, 1'b0, 32'h0};

        rst = 1'b1; m_ready = 1'b1;
        s0_data = '0; s0_bytes = '0; s0_last = 1'b0; s0_valid = 1'b0;
        s1_data = '0; s1_bytes = '0; s1_last = 1'b0; s1_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_grant", {30'd0, grant}, 32'd0);
        chk("rst_occ", {27'd0, occ}, 32'd0);
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_m_bytes", {29'd0, m_bytes}, 32'd0);
        chk("rst_m_last", {31'd0, m_last}, 32'd0);
        chk("rst_ready", {30'd0, s1_ready, s0_ready}, 32'd0);
        chk("rst_strobes", {22'd0, fifo_wr_en, fifo_rd_en, fifo_din_index, fifo_dout_index}, 32'd0);
        @(posedge clk);
        #1;

        run_table("single");

        // 2+3+2 byte packet from s1: one full word then a 3-byte last word
        exp_q.push_back('{32'hAABBCCDD, 3'd4, 1'b0});
        exp_q.push_back('{32'hEE112200, 3'd3, 1'b1});
        send(1'b1, 32'hAABB1234, 3'd2, 1'b0);
        send(1'b1, 32'hCCDDEE56, 3'd3, 1'b0);
        send(1'b1, 32'h11229ABC, 3'd2, 1'b1);
        drain("tail");

        w0 = wr_ops; r0 = rd_ops;
        exp_q.push_back('{32'h0, 3'd0, 1'b1});
        send(1'b0, 32'hDEADBEEF, 3'd0, 1'b1);
        drain("zero");
        chk("zero_no_fifo_write", wr_ops - w0, 32'd0);
        chk("zero_no_fifo_read", rd_ops - r0, 32'd0);

        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.push_back('{32'hA0A1A2A3, 3'd4, 1'b1});
        exp_q.push_back('{32'hB0B1B2B3, 3'd4, 1'b1});
        contend(32'hA0A1A2A3, 32'hB0B1B2B3, first);
        drain("cont1");
        chk("cont1_first_s0", first, 32'd0);
        exp_q.push_back('{32'hC0C1C2C3, 3'd4, 1'b1});
        exp_q.push_back('{32'hD0D1D2D3, 3'd4, 1'b1});
        contend(32'hC0C1C2C3, 32'hD0D1D2D3, first);
        drain("cont2");
        chk("cont2_first_s0", first, 32'd0);

        // Stalled output: one word parks in m_data, the FIFO fills to capacity
        m_ready = 1'b0;
        for (int k = 0; k < 5; k++)
            send(1'b0, {8'(4*k+1), 8'(4*k+2), 8'(4*k+3), 8'(4*k+4)}, 3'd4, 1'b0);
        s0_data = {8'd21, 8'd22, 8'd23, 8'd24}; s0_bytes = 3'd4; s0_last = 1'b1; s0_valid = 1'b1;
        step();
        step();
        chk("bp_s0_ready_low", {31'd0, snap_s0r}, 32'd0);
        chk("bp_occ_full", {27'd0, occ}, DEPTH);
        chk("bp_m_valid_held", {31'd0, m_valid}, 32'd1);
        for (int k = 0; k < 6; k++)
            exp_q.push_back('{{8'(4*k+1), 8'(4*k+2), 8'(4*k+3), 8'(4*k+4)}, 3'd4, (k == 5)});
        m_ready = 1'b1;
        send(1'b0, {8'd21, 8'd22, 8'd23, 8'd24}, 3'd4, 1'b1);
        drain("bp");

        // Reset while DRAIN holds 6 bytes and a stalled word
        m_ready = 1'b0;
        send(1'b0, 32'hA1A2A3A4, 3'd4, 1'b0);
        send(1'b0, 32'hB1B2B3B4, 3'd4, 1'b0);
        send(1'b0, 32'hC1C20000, 3'd2, 1'b1);
        step();
        chk("rdrain_pre_occ", {27'd0, occ}, 32'd6);
        chk("rdrain_pre_m_valid", {31'd0, m_valid}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rdrain_occ", {27'd0, occ}, 32'd0);
        chk("rdrain_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rdrain_grant", {30'd0, grant}, 32'd0);
        @(posedge clk);
        #1;
        run_table("after_rst");

        chk("fifo_over_under_run", fifo_errs, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
